ats_eligibility_gate: RTL and testbench
=======================================

# ats_eligibility_gate

Holds per-frame eligibility timestamps produced by the ATS `process_frame_core` until the switch time reaches them, then releases them in arrival order to the downstream transmission selector. Entries whose eligibility lies further in the future than the configured maximum residence time are discarded at ingress, as ATS requires. The block sits between `process_frame_core` and the egress queue scheduler.

## Interface

**Parameters**
- `TIMESTAMP_WIDTH`, default 72: timestamp width in ps.
- `FIFO_DEPTH`, default 16: queued timestamps. Power of two, at least 2.
- `COUNTER_WIDTH`, default 32: width of the statistics counters.

**Ports**
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `current_time`  in  TIMESTAMP_WIDTH: free-running switch time in ps.
- `max_residence_time`  in  TIMESTAMP_WIDTH: discard threshold in ps. Quasi-static.
- `s_axis_eligibility_timestamp_tdata`  in  TIMESTAMP_WIDTH: eligibility time.
- `s_axis_eligibility_timestamp_tvalid`  in  1.
- `s_axis_eligibility_timestamp_tready`  out  1.
- `m_axis_release_tdata`  out  TIMESTAMP_WIDTH: the eligibility time being released.
- `m_axis_release_tvalid`  out  1.
- `m_axis_release_tready`  in  1.
- `drop_pulse`  out  1: one-cycle pulse per discarded entry.
- `release_count`  out  COUNTER_WIDTH: saturating count of released entries.
- `drop_count`  out  COUNTER_WIDTH: saturating count of dropped entries.

## Operation

**Ingress**
- Accept on `tvalid & tready`.
- Drop condition: `tdata > current_time` and `tdata - current_time > max_residence_time`. Unsigned, full width.
- An accepted entry that meets the drop condition is not enqueued, pulses `drop_pulse` and increments `drop_count`.
- Every other accepted entry is written to the FIFO.
- An entry with `tdata <= current_time` is never dropped.

**Head state machine**
- `EMPTY`: no head loaded. If the FIFO is non-empty, pop the FIFO into the head register and go to `WAIT`.
- `WAIT`: compare the head register against `current_time` every cycle. If `head <= current_time`, go to `VALID`.
- `VALID`: `m_axis_release_tvalid = 1`, `tdata = head`. Hold until `tready`.
  - On handshake, increment `release_count`.
  - On handshake with the FIFO non-empty: pop the next entry into the head register and go to `WAIT`.
  - On handshake with the FIFO empty: go to `EMPTY`.
- Order is strict FIFO. A later entry with an earlier timestamp waits behind the head (head-of-line blocking is intended).
- Time comparison is plain unsigned with no wrap handling; 72-bit ps does not wrap in service.

**Counters**
- Saturate at all-ones and never wrap.

## Timing

**Reset values**
- `s_axis_..._tready` = 0 during reset, 1 in the first cycle after reset.
- `m_axis_release_tvalid` = 0, `m_axis_release_tdata` = 0.
- `drop_pulse` = 0, both counters = 0, FSM = `EMPTY`, FIFO empty.

**Handshakes and outputs**
- `tready` is registered and equals `!full`.
- A pop in the same cycle as an accept does not raise `tready` in that cycle.
- With the FIFO full, `tvalid` is ignored and nothing is accepted.
- `drop_pulse` is registered: it is high in the cycle after the accepting edge.
- `m_axis_release_tvalid` and `tdata` are registered.
- `tdata` is stable while `tvalid=1 & tready=0`.

**Latency and throughput**
- An already-eligible entry accepted into an empty block: `tvalid` rises 2 edges after the accepting edge (edge 1: pop to head; edge 2: `WAIT` to `VALID`).
- Peak throughput: one release per 2 cycles.
- A simultaneous ingress write and head pop are both honoured. Occupancy is then unchanged.

**Reset mid-operation**
- All queued entries and the head are discarded without release or drop counting.
- Outputs return to their reset values on the next edge.

## Structure

- Shared package `ats_pkg`:
  - `TIMESTAMP_WIDTH` default constant (72).
  - FSM state enum `gate_state_t` (`EMPTY`, `WAIT`, `VALID`).
  - Saturating-increment function reused by other ATS counters.
- One sub-module, `ats_timestamp_fifo`: synchronous FIFO with registered `full`/`empty`, simultaneous push and pop, and a registered `count`.
- The gate itself holds the drop comparator, the head register, the FSM and the counters.

## Test plan

The bench drives `current_time` starting at 1000, incrementing by 8000 per cycle, with `max_residence_time` = 1,000,000.

1. Push 500 into the empty block → `tvalid` 2 edges later, `tdata` = 500, `release_count` = 1.
2. Push `current_time + 80,000` → held in `WAIT` for 10 cycles, then released with the same `tdata`.
3. Push `current_time + 2,000,000` → `drop_pulse` high for 1 cycle, `drop_count` = 1, no release.
4. With `m_tready` = 0, push 17 already-eligible entries → the 1st loads the head, the next 16 fill the FIFO and `tready` falls. The 18th is not accepted until `m_tready` = 1. Then all 17 release in order.
5. Push 900,000 then 100 at time 1000 → 900,000 releases first; 100 releases 2 cycles after it.
6. Assert `rstn` = 0 for 1 cycle with 5 entries queued → no releases afterwards, counters = 0, `tready` = 1 the cycle after reset.

Source files
------------

// File: rtl/ats_pkg.sv
// Shared ATS definitions: default timestamp width, eligibility-gate FSM
// states and a saturating-increment helper used by the ATS statistics counters.
package ats_pkg;

    localparam int unsigned TIMESTAMP_WIDTH = 72;
    localparam int unsigned SAT_INC_WIDTH   = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } gate_state_t;

    // Increment a counter of 'width' bits (<= 64), sticking at all-ones.
    function automatic logic [SAT_INC_WIDTH-1:0] sat_inc(
        input logic [SAT_INC_WIDTH-1:0] value,
        input int unsigned              width
    );
        logic [SAT_INC_WIDTH-1:0] max_v;
        max_v = (width >= SAT_INC_WIDTH) ? '1
                                         : ((SAT_INC_WIDTH'(1) << width) - SAT_INC_WIDTH'(1));
        return (value >= max_v) ? max_v : value + SAT_INC_WIDTH'(1);
    endfunction

endpackage

// File: rtl/ats_eligibility_gate_if.sv
// AXI-Stream style valid/ready channel carrying one timestamp.
//   tdata  : timestamp in ps
//   tvalid : source has data
//   tready : sink can accept
interface ats_eligibility_gate_if #(
    parameter int unsigned WIDTH = ats_pkg::TIMESTAMP_WIDTH
) ();

    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);

endinterface

// File: rtl/ats_timestamp_fifo.sv
// Synchronous timestamp FIFO with simultaneous push/pop and registered flags.
//   clk, rstn       : clock, synchronous active-low reset
//   i_push, i_data  : write request and data (ignored when full)
//   i_pop           : read request (ignored when empty)
//   o_data_c        : head-of-FIFO data (combinational read of storage)
//   o_full, o_empty : registered occupancy flags
//   o_full_next_c   : flag value the FIFO will hold after this edge
module ats_timestamp_fifo #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data_c,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_full_next_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_next;

    assign w_push       = i_push & ~r_full;
    assign w_pop        = i_pop & ~r_empty;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // Pointer, occupancy and flag registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage needs no reset: only slots behind the write pointer are read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data_c      = r_mem[r_rd_ptr];
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_full_next_c = (w_count_next == CW'(DEPTH));

endmodule

// File: rtl/ats_eligibility_gate.sv
// ATS eligibility gate: queues eligibility timestamps, drops those further in
// the future than max_residence_time, and releases the rest in arrival order
// once current_time reaches them.
//   clk, rstn                     : clock, synchronous active-low reset
//   current_time                  : free-running switch time (ps)
//   max_residence_time            : discard threshold (ps), quasi-static
//   s_axis_eligibility_timestamp  : ingress timestamp stream (slave)
//   m_axis_release                : released timestamp stream (master)
//   drop_pulse                    : one-cycle pulse per discarded entry
//   release_count, drop_count     : saturating statistics counters
module ats_eligibility_gate #(
    parameter int unsigned TIMESTAMP_WIDTH = ats_pkg::TIMESTAMP_WIDTH,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned COUNTER_WIDTH   = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [TIMESTAMP_WIDTH-1:0]  current_time,
    input  logic [TIMESTAMP_WIDTH-1:0]  max_residence_time,
    ats_eligibility_gate_if.slave       s_axis_eligibility_timestamp,
    ats_eligibility_gate_if.master      m_axis_release,
    output logic                        drop_pulse,
    output logic [COUNTER_WIDTH-1:0]    release_count,
    output logic [COUNTER_WIDTH-1:0]    drop_count
);

    import ats_pkg::*;

    gate_state_t                r_state;
    gate_state_t                w_state_next;
    logic [TIMESTAMP_WIDTH-1:0] r_head;
    logic                       r_m_tvalid;
    logic                       r_s_tready;
    logic                       r_drop_pulse;
    logic [COUNTER_WIDTH-1:0]   r_release_count;
    logic [COUNTER_WIDTH-1:0]   r_drop_count;

    logic [TIMESTAMP_WIDTH-1:0] w_in_data;
    logic [TIMESTAMP_WIDTH-1:0] w_ahead;
    logic                       w_accept;
    logic                       w_drop_cond;
    logic                       w_drop;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_release;
    logic [TIMESTAMP_WIDTH-1:0] w_fifo_data;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic                       w_fifo_full_next;

    // Ingress: the full check is redundant with tready but keeps the FIFO safe
    assign w_in_data   = s_axis_eligibility_timestamp.tdata;
    assign w_accept    = s_axis_eligibility_timestamp.tvalid & r_s_tready & ~w_fifo_full;
    assign w_ahead     = w_in_data - current_time;
    assign w_drop_cond = (w_in_data > current_time) && (w_ahead > max_residence_time);
    assign w_drop      = w_accept & w_drop_cond;
    assign w_push      = w_accept & ~w_drop_cond;

    ats_timestamp_fifo #(
        .WIDTH (TIMESTAMP_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rstn          (rstn),
        .i_push        (w_push),
        .i_data        (w_in_data),
        .i_pop         (w_pop),
        .o_data_c      (w_fifo_data),
        .o_full        (w_fifo_full),
        .o_empty       (w_fifo_empty),
        .o_full_next_c (w_fifo_full_next)
    );

    // Head FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= EMPTY;
        else       r_state <= w_state_next;
    end

    // Head FSM next state; a pop always reloads the head register
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (r_head <= current_time) w_state_next = VALID;
            end
            VALID: begin
                if (m_axis_release.tready) begin
                    w_release = 1'b1;
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = WAIT;
                    end else begin
                        w_state_next = EMPTY;
                    end
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    // Head register, registered handshake outputs and statistics
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head          <= '0;
            r_m_tvalid      <= 1'b0;
            r_s_tready      <= 1'b0;
            r_drop_pulse    <= 1'b0;
            r_release_count <= '0;
            r_drop_count    <= '0;
        end else begin
            if (w_pop) r_head <= w_fifo_data;
            r_m_tvalid   <= (w_state_next == VALID);
            r_s_tready   <= ~w_fifo_full_next;
            r_drop_pulse <= w_drop;
            if (w_release)
                r_release_count <= COUNTER_WIDTH'(sat_inc(SAT_INC_WIDTH'(r_release_count), COUNTER_WIDTH));
            if (w_drop)
                r_drop_count <= COUNTER_WIDTH'(sat_inc(SAT_INC_WIDTH'(r_drop_count), COUNTER_WIDTH));
        end
    end

    assign s_axis_eligibility_timestamp.tready = r_s_tready;
    assign m_axis_release.tvalid               = r_m_tvalid;
    assign m_axis_release.tdata                = r_head;
    assign drop_pulse                          = r_drop_pulse;
    assign release_count                       = r_release_count;
    assign drop_count                          = r_drop_count;

endmodule

// File: tb/tb_ats_eligibility_gate.sv
// Directed bench for ats_eligibility_gate with a release-order scoreboard.
module tb_ats_eligibility_gate;

    localparam int unsigned TW    = 72;
    localparam int unsigned CNTW  = 32;
    localparam logic [TW-1:0] STEP    = TW'(8000);
    localparam logic [TW-1:0] MAX_RES = TW'(1_000_000);
    localparam int unsigned BOUND = 300;

    logic            clk = 1'b0;
    logic            rstn;
    logic [TW-1:0]   current_time;
    logic [TW-1:0]   max_residence_time;
    logic            drop_pulse;
    logic [CNTW-1:0] release_count;
    logic [CNTW-1:0] drop_count;

    ats_eligibility_gate_if #(.WIDTH(TW)) s_if ();
    ats_eligibility_gate_if #(.WIDTH(TW)) m_if ();

    ats_eligibility_gate #(
        .TIMESTAMP_WIDTH (TW),
        .FIFO_DEPTH      (16),
        .COUNTER_WIDTH   (CNTW)
    ) dut (
        .clk                          (clk),
        .rstn                         (rstn),
        .current_time                 (current_time),
        .max_residence_time           (max_residence_time),
        .s_axis_eligibility_timestamp (s_if),
        .m_axis_release               (m_if),
        .drop_pulse                   (drop_pulse),
        .release_count                (release_count),
        .drop_count                   (drop_count)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cycle   = 0;
    int            last_rel_cycle = 0;
    logic          last_acc = 1'b0;
    int            m_rel  = 0;
    int            m_drop = 0;
    logic [TW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes before the edge, update model, check after it
    task automatic tick();
        logic          hs, hold, acc, rst_edge, exp_drop;
        logic [TW-1:0] rel_d, in_d;
        rst_edge = !rstn;
        hs       = rstn && m_if.tvalid && m_if.tready;
        hold     = rstn && m_if.tvalid && !m_if.tready;
        acc      = rstn && s_if.tvalid && s_if.tready;
        rel_d    = m_if.tdata;
        in_d     = s_if.tdata;
        exp_drop = acc && (in_d > current_time) && ((in_d - current_time) > MAX_RES);
        @(posedge clk);
        #1;
        cycle++;
        last_acc = acc;
        if (rst_edge) begin
            exp_q.delete();
            m_rel  = 0;
            m_drop = 0;
        end else begin
            if (acc && !exp_drop) exp_q.push_back(in_d);
            if (exp_drop) m_drop++;
            if (hs) begin
                m_rel++;
                last_rel_cycle = cycle;
                check("release_expected", TW'(1), TW'(exp_q.size() != 0));
                if (exp_q.size() != 0) check("release_order", rel_d, exp_q.pop_front());
            end
            if (hold && m_if.tvalid) check("tdata_stable", m_if.tdata, rel_d);
            check("drop_pulse", TW'(drop_pulse), TW'(exp_drop));
            check("drop_count", TW'(drop_count), TW'(m_drop));
            check("release_count", TW'(release_count), TW'(m_rel));
        end
        current_time = current_time + STEP;
    endtask

    task automatic push(input logic [TW-1:0] d);
        int n;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < BOUND);
        s_if.tvalid = 1'b0;
        if (!last_acc) check("push_timeout", TW'(0), TW'(1));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!m_if.tvalid && n < BOUND) begin
            tick();
            n++;
        end
        if (!m_if.tvalid) check("valid_timeout", TW'(0), TW'(1));
    endtask

    initial begin
        int n, c1;
        rstn               = 1'b0;
        current_time       = '0;
        max_residence_time = MAX_RES;
        s_if.tdata         = '0;
        s_if.tvalid        = 1'b0;
        m_if.tready        = 1'b1;

        // Reset values
        repeat (3) tick();
        check("rst_s_tready", TW'(s_if.tready), TW'(0));
        check("rst_m_tvalid", TW'(m_if.tvalid), TW'(0));
        check("rst_m_tdata", m_if.tdata, TW'(0));
        check("rst_drop_pulse", TW'(drop_pulse), TW'(0));
        check("rst_release_count", TW'(release_count), TW'(0));
        check("rst_drop_count", TW'(drop_count), TW'(0));
        rstn = 1'b1;
        current_time = TW'(1000);
        tick();
        check("tready_after_reset", TW'(s_if.tready), TW'(1));

        // 1: already-eligible entry, 2-edge latency
        push(TW'(500));
        check("t1_tvalid_low", TW'(m_if.tvalid), TW'(0));
        wait_valid(n);
        check("t1_latency", TW'(n), TW'(2));
        check("t1_tdata", m_if.tdata, TW'(500));
        tick();
        check("t1_release_count", TW'(release_count), TW'(1));

        // 1b: head equal to current_time on the compare edge is eligible
        push(current_time + TW'(16000));
        wait_valid(n);
        check("t1b_equal_latency", TW'(n), TW'(2));
        tick();

        // 2: future entry waits until current_time reaches it
        push(current_time + TW'(80000));
        wait_valid(n);
        check("t2_wait_cycles", TW'(n), TW'(10));
        tick();
        check("t2_release_count", TW'(release_count), TW'(3));

        // 3: beyond max residence time is dropped
        push(current_time + TW'(2_000_000));
        check("t3_drop_pulse", TW'(drop_pulse), TW'(1));
        check("t3_drop_count", TW'(drop_count), TW'(1));
        tick();
        check("t3_drop_pulse_low", TW'(drop_pulse), TW'(0));
        repeat (5) tick();
        check("t3_no_release", TW'(m_if.tvalid), TW'(0));

        // 4: fill head + FIFO with downstream stalled
        m_if.tready = 1'b0;
        for (int i = 0; i < 17; i++) push(TW'(100 + i));
        check("t4_tready_full", TW'(s_if.tready), TW'(0));
        check("t4_head_valid", TW'(m_if.tvalid), TW'(1));
        check("t4_head_data", m_if.tdata, TW'(100));
        s_if.tdata  = TW'(200);
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_18th_blocked", TW'(last_acc), TW'(0));
        end
        m_if.tready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < BOUND);
        s_if.tvalid = 1'b0;
        check("t4_18th_accepted", TW'(last_acc), TW'(1));
        n = 0;
        while (exp_q.size() != 0 && n < BOUND) begin
            tick();
            n++;
        end
        check("t4_drained", TW'(exp_q.size()), TW'(0));
        repeat (2) tick();
        check("t4_idle", TW'(m_if.tvalid), TW'(0));
        check("t4_release_count", TW'(release_count), TW'(21));

        // 5: head-of-line blocking, strict arrival order
        current_time = TW'(1000);
        push(TW'(900_000));
        push(TW'(100));
        wait_valid(n);
        check("t5_first_data", m_if.tdata, TW'(900_000));
        tick();
        c1 = last_rel_cycle;
        wait_valid(n);
        check("t5_second_data", m_if.tdata, TW'(100));
        tick();
        check("t5_release_gap", TW'(last_rel_cycle - c1), TW'(2));

        // 6: reset with entries queued; boundary diff == max is kept
        m_if.tready = 1'b0;
        for (int i = 0; i < 4; i++) push(current_time);
        push(current_time + MAX_RES);
        check("t6_boundary_not_dropped", TW'(drop_count), TW'(1));
        rstn = 1'b0;
        tick();
        check("t6_rst_m_tvalid", TW'(m_if.tvalid), TW'(0));
        check("t6_rst_m_tdata", m_if.tdata, TW'(0));
        check("t6_rst_s_tready", TW'(s_if.tready), TW'(0));
        check("t6_rst_release_count", TW'(release_count), TW'(0));
        check("t6_rst_drop_count", TW'(drop_count), TW'(0));
        rstn = 1'b1;
        tick();
        check("t6_tready_after_reset", TW'(s_if.tready), TW'(1));
        m_if.tready = 1'b1;
        repeat (20) tick();
        check("t6_no_release", TW'(release_count), TW'(0));
        check("t6_tvalid_low", TW'(m_if.tvalid), TW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
